// File: rtl/dram_arb_pkg.sv
// rtl/dram_arb_pkg.sv - shared types and constants for the two-master DRAM arbiter
package dram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam logic M_IF = 1'b0;
    localparam logic M_LS = 1'b1;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } req_t;

endpackage

// File: rtl/dram_arb_grant.sv
// rtl/dram_arb_grant.sv - grant selection; DRAM_ARB_RR_EN selects round-robin, else m1 fixed priority
module dram_arb_grant
    import dram_arb_pkg::*;
(
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    output logic grant_id,
    output logic grant_valid
);

`ifdef DRAM_ARB_RR_EN
    always_comb begin
        grant_valid = valid0 | valid1;
        if (valid0 && valid1) begin
            grant_id = ~last_grant;
        end else begin
            grant_id = valid1 ? M_LS : M_IF;
        end
    end
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    always_comb begin
        grant_valid = valid0 | valid1;
        grant_id    = valid1 ? M_LS : M_IF;
    end
`endif

endmodule

// File: rtl/dram_arbiter.sv
// rtl/dram_arbiter.sv - two-master DRAM arbiter/sequencer (IDLE/ACCESS/RESP); DRAM_ARB_RR_EN enables round-robin
module dram_arbiter
    import dram_arb_pkg::*;
#(
    parameter int ADDR_BITS = 20
) (
    input  logic                 clk,
    input  logic                 rst_n,

    input  logic                 m0_req_valid,
    output logic                 m0_req_ready,
    input  logic [31:0]          m0_req_addr,
    input  logic                 m0_req_we,
    input  logic [3:0]           m0_req_be,
    input  logic [31:0]          m0_req_wdata,
    output logic                 m0_rsp_valid,
    input  logic                 m0_rsp_ready,
    output logic [31:0]          m0_rsp_rdata,

    input  logic                 m1_req_valid,
    output logic                 m1_req_ready,
    input  logic [31:0]          m1_req_addr,
    input  logic                 m1_req_we,
    input  logic [3:0]           m1_req_be,
    input  logic [31:0]          m1_req_wdata,
    output logic                 m1_rsp_valid,
    input  logic                 m1_rsp_ready,
    output logic [31:0]          m1_rsp_rdata,

    output logic [ADDR_BITS-1:0] dram_a,
    output logic [3:0]           dram_be,
    output logic                 dram_we,
    output logic [31:0]          dram_d,
    input  logic [31:0]          dram_spo
);

    state_e      state_q, state_d;
    req_t        req_q, req_d;
    logic        gid_q, gid_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rsp_valid_q, rsp_valid_d;
    logic        dram_we_q, dram_we_d;
    logic [3:0]  dram_be_q, dram_be_d;

    logic        last_grant;
    logic        grant_id;
    logic        grant_valid;
    logic        accept;
    logic        rsp_ready_sel;
    req_t        sel_req;

`ifdef DRAM_ARB_RR_EN
    logic        last_grant_q, last_grant_d;
    assign last_grant = last_grant_q;
`else
    assign last_grant = 1'b1;
`endif

    dram_arb_grant u_grant (
        .valid0      (m0_req_valid),
        .valid1      (m1_req_valid),
        .last_grant  (last_grant),
        .grant_id    (grant_id),
        .grant_valid (grant_valid)
    );

    // Gated by rst_n so nothing is offered while reset is held.
    assign accept       = rst_n && (state_q == IDLE) && grant_valid;
    assign m0_req_ready = accept && (grant_id == M_IF);
    assign m1_req_ready = accept && (grant_id == M_LS);

    assign rsp_ready_sel = gid_q ? m1_rsp_ready : m0_rsp_ready;

    always_comb begin
        sel_req       = '0;
        sel_req.addr  = grant_id ? m1_req_addr  : m0_req_addr;
        sel_req.we    = grant_id ? m1_req_we    : m0_req_we;
        sel_req.be    = grant_id ? m1_req_be    : m0_req_be;
        sel_req.wdata = grant_id ? m1_req_wdata : m0_req_wdata;
    end

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        gid_d       = gid_q;
        rdata_d     = rdata_q;
        rsp_valid_d = rsp_valid_q;
        dram_we_d   = dram_we_q;
        dram_be_d   = dram_be_q;
`ifdef DRAM_ARB_RR_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    req_d     = sel_req;
                    gid_d     = grant_id;
                    dram_we_d = sel_req.we;
                    dram_be_d = sel_req.we ? sel_req.be : 4'b0000;
                    state_d   = ACCESS;
`ifdef DRAM_ARB_RR_EN
                    last_grant_d = ~last_grant_q;
`endif
                end
            end
            ACCESS: begin
                // A write commits at this edge; spo still shows the pre-write word.
                rdata_d     = dram_spo;
                dram_we_d   = 1'b0;
                dram_be_d   = 4'b0000;
                rsp_valid_d = gid_q ? 2'b10 : 2'b01;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready_sel) begin
                    rsp_valid_d = 2'b00;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_q       <= '0;
            gid_q       <= 1'b0;
            rdata_q     <= '0;
            rsp_valid_q <= '0;
            dram_we_q   <= 1'b0;
            dram_be_q   <= '0;
`ifdef DRAM_ARB_RR_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            gid_q       <= gid_d;
            rdata_q     <= rdata_d;
            rsp_valid_q <= rsp_valid_d;
            dram_we_q   <= dram_we_d;
            dram_be_q   <= dram_be_d;
`ifdef DRAM_ARB_RR_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    logic unused_req_bits;
    assign unused_req_bits = ^{req_q.addr[31:ADDR_BITS+2], req_q.addr[1:0], req_q.we, req_q.be};

    assign dram_a       = req_q.addr[ADDR_BITS+1:2];
    assign dram_d       = req_q.wdata;
    assign dram_we      = dram_we_q;
    assign dram_be      = dram_be_q;
    assign m0_rsp_valid = rsp_valid_q[0];
    assign m1_rsp_valid = rsp_valid_q[1];
    assign m0_rsp_rdata = rdata_q;
    assign m1_rsp_rdata = rdata_q;

endmodule

// File: tb/tb_dram_arbiter.sv
// tb/tb_dram_arbiter.sv - directed self-checking bench for dram_arbiter
module tb_dram_arbiter;

    logic        clk;
    logic        rst_n;
    logic        m0_req_valid, m0_req_ready, m0_req_we, m0_rsp_valid, m0_rsp_ready;
    logic [31:0] m0_req_addr, m0_req_wdata, m0_rsp_rdata;
    logic [3:0]  m0_req_be;
    logic        m1_req_valid, m1_req_ready, m1_req_we, m1_rsp_valid, m1_rsp_ready;
    logic [31:0] m1_req_addr, m1_req_wdata, m1_rsp_rdata;
    logic [3:0]  m1_req_be;
    logic [19:0] dram_a;
    logic [3:0]  dram_be;
    logic        dram_we;
    logic [31:0] dram_d;
    logic [31:0] dram_spo;

    logic [31:0] mem [0:63];
    logic        poke;
    logic [5:0]  poke_a;
    logic [31:0] poke_d;
    logic        unused_hi;

    int checks = 0;
    int errors = 0;

    dram_arbiter #(.ADDR_BITS(20)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_addr(m0_req_addr),
        .m0_req_we(m0_req_we), .m0_req_be(m0_req_be), .m0_req_wdata(m0_req_wdata),
        .m0_rsp_valid(m0_rsp_valid), .m0_rsp_ready(m0_rsp_ready), .m0_rsp_rdata(m0_rsp_rdata),
        .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_addr(m1_req_addr),
        .m1_req_we(m1_req_we), .m1_req_be(m1_req_be), .m1_req_wdata(m1_req_wdata),
        .m1_rsp_valid(m1_rsp_valid), .m1_rsp_ready(m1_rsp_ready), .m1_rsp_rdata(m1_rsp_rdata),
        .dram_a(dram_a), .dram_be(dram_be), .dram_we(dram_we), .dram_d(dram_d), .dram_spo(dram_spo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Small DRAM model: async read, byte-enabled synchronous write.
    assign dram_spo  = mem[dram_a[5:0]];
    assign unused_hi = ^dram_a[19:6];
    always @(posedge clk) begin
        if (poke) begin
            mem[poke_a] <= poke_d;
        end else if (dram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (dram_be[b]) mem[dram_a[5:0]][8*b +: 8] <= dram_d[8*b +: 8];
            end
        end
    end

    task automatic write_mem(input logic [5:0] a, input logic [31:0] d);
        poke = 1'b1; poke_a = a; poke_d = d;
        @(negedge clk);
        poke = 1'b0;
    endtask

    task automatic idle_inputs;
        m0_req_valid = 0; m0_req_addr = 0; m0_req_we = 0; m0_req_be = 0; m0_req_wdata = 0; m0_rsp_ready = 1;
        m1_req_valid = 0; m1_req_addr = 0; m1_req_we = 0; m1_req_be = 0; m1_req_wdata = 0; m1_rsp_ready = 1;
    endtask

    task automatic pulse_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        m0_req_valid = 1; m1_req_valid = 1;
        @(negedge clk);
        checks++;
        if ({m0_req_ready, m1_req_ready} !== 2'b00) begin
            errors++; $display("FAIL reset_req_ready got %b want 00", {m0_req_ready, m1_req_ready});
        end
        checks++;
        if ({m0_rsp_valid, m1_rsp_valid, m0_rsp_rdata, dram_a, dram_we, dram_be, dram_d} !== '0) begin
            errors++; $display("FAIL reset_outputs rsp_v=%b%b rdata=%h a=%h we=%b be=%b d=%h want all 0",
                               m0_rsp_valid, m1_rsp_valid, m0_rsp_rdata, dram_a, dram_we, dram_be, dram_d);
        end
        m0_req_valid = 0; m1_req_valid = 0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_read;
        write_mem(6'd4, 32'hDEADBEEF);
        m0_req_valid = 1; m0_req_addr = 32'h0000_0010; m0_req_we = 0;
        #1;
        checks++;
        if (m0_req_ready !== 1'b1) begin errors++; $display("FAIL read_ready got %b want 1", m0_req_ready); end
        @(negedge clk);
        m0_req_valid = 0;
        checks++;
        if ({dram_a, dram_we, dram_be, m0_rsp_valid} !== {20'd4, 1'b0, 4'b0000, 1'b0}) begin
            errors++; $display("FAIL read_access a=%h we=%b be=%b rsp_v=%b want a=4 we=0 be=0 rsp_v=0",
                               dram_a, dram_we, dram_be, m0_rsp_valid);
        end
        @(negedge clk);
        checks++;
        if ({m0_rsp_valid, m1_rsp_valid, m0_rsp_rdata} !== {2'b10, 32'hDEADBEEF}) begin
            errors++; $display("FAIL read_resp v0=%b v1=%b rdata=%h want 1 0 deadbeef",
                               m0_rsp_valid, m1_rsp_valid, m0_rsp_rdata);
        end
        @(negedge clk);
        checks++;
        if (m0_rsp_valid !== 1'b0) begin errors++; $display("FAIL read_rsp_drop got %b want 0", m0_rsp_valid); end
    endtask

    task automatic test_write;
        write_mem(6'd2, 32'hAABBCCDD);
        m1_req_valid = 1; m1_req_addr = 32'h0000_0008; m1_req_we = 1; m1_req_be = 4'b0101; m1_req_wdata = 32'h11223344;
        #1;
        checks++;
        if (m1_req_ready !== 1'b1) begin errors++; $display("FAIL write_ready got %b want 1", m1_req_ready); end
        @(negedge clk);
        m1_req_valid = 0;
        checks++;
        if ({dram_a, dram_we, dram_be, dram_d} !== {20'd2, 1'b1, 4'b0101, 32'h11223344}) begin
            errors++; $display("FAIL write_access a=%h we=%b be=%b d=%h want 2 1 0101 11223344",
                               dram_a, dram_we, dram_be, dram_d);
        end
        @(negedge clk);
        checks++;
        if ({m1_rsp_valid, m1_rsp_rdata} !== {1'b1, 32'hAABBCCDD}) begin
            errors++; $display("FAIL write_resp v=%b rdata=%h want 1 aabbccdd", m1_rsp_valid, m1_rsp_rdata);
        end
        checks++;
        if ({dram_we, dram_be} !== 5'b0) begin
            errors++; $display("FAIL write_we_after we=%b be=%b want 0", dram_we, dram_be);
        end
        checks++;
        if (mem[2] !== 32'hAA22CC44) begin errors++; $display("FAIL write_mem got %h want aa22cc44", mem[2]); end
        @(negedge clk);
        m1_req_valid = 1; m1_req_we = 0;
        @(negedge clk);
        m1_req_valid = 0;
        @(negedge clk);
        checks++;
        if ({m1_rsp_valid, m1_rsp_rdata} !== {1'b1, 32'hAA22CC44}) begin
            errors++; $display("FAIL readback v=%b rdata=%h want 1 aa22cc44", m1_rsp_valid, m1_rsp_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_arbitration;
        logic [3:0] exp_win;
`ifdef DRAM_ARB_RR_EN
        exp_win = 4'b1010;
`else
        exp_win = 4'b1111;
`endif
        write_mem(6'd8, 32'h0000A0A0);
        write_mem(6'd9, 32'h0000B1B1);
        pulse_reset;
        m0_req_valid = 1; m0_req_addr = 32'h20; m0_req_we = 0;
        m1_req_valid = 1; m1_req_addr = 32'h24; m1_req_we = 0;
        for (int r = 0; r < 4; r++) begin
            #1;
            checks++;
            if ({m1_req_ready, m0_req_ready} !== (exp_win[r] ? 2'b10 : 2'b01)) begin
                errors++; $display("FAIL arb_round%0d ready m1m0=%b%b want winner m%0d", r, m1_req_ready, m0_req_ready, exp_win[r]);
            end
            @(negedge clk);
            @(negedge clk);
            checks++;
            if ({m1_rsp_valid, m0_rsp_valid, m0_rsp_rdata} !==
                (exp_win[r] ? {2'b10, 32'h0000B1B1} : {2'b01, 32'h0000A0A0})) begin
                errors++; $display("FAIL arb_resp%0d v1v0=%b%b rdata=%h want winner m%0d", r, m1_rsp_valid, m0_rsp_valid, m0_rsp_rdata, exp_win[r]);
            end
            @(negedge clk);
        end
        m0_req_valid = 0; m1_req_valid = 0;
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        m0_req_valid = 1; m0_req_addr = 32'h20; m0_req_we = 0; m0_rsp_ready = 0;
        @(negedge clk);
        m0_req_valid = 0;
        m1_req_valid = 1; m1_req_addr = 32'h24; m1_req_we = 0;
        #1;
        checks++;
        if (m1_req_ready !== 1'b0) begin errors++; $display("FAIL bp_access_ready got %b want 0", m1_req_ready); end
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({m0_rsp_valid, m1_req_ready, m0_rsp_rdata} !== {2'b10, 32'h0000A0A0}) begin
                errors++; $display("FAIL bp_hold%0d rsp_v=%b m1_ready=%b rdata=%h want 1 0 0000a0a0", i, m0_rsp_valid, m1_req_ready, m0_rsp_rdata);
            end
            @(negedge clk);
        end
        m0_rsp_ready = 1;
        #1;
        checks++;
        if (m1_req_ready !== 1'b0) begin errors++; $display("FAIL bp_release_ready got %b want 0", m1_req_ready); end
        @(negedge clk);
        checks++;
        if ({m1_req_ready, m0_rsp_valid} !== 2'b10) begin
            errors++; $display("FAIL bp_idle_accept m1_ready=%b m0_rsp_v=%b want 1 0", m1_req_ready, m0_rsp_valid);
        end
        @(negedge clk);
        m1_req_valid = 0;
        @(negedge clk);
        checks++;
        if ({m1_rsp_valid, m1_rsp_rdata} !== {1'b1, 32'h0000B1B1}) begin
            errors++; $display("FAIL bp_m1_resp v=%b rdata=%h want 1 0000b1b1", m1_rsp_valid, m1_rsp_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_access;
        write_mem(6'd3, 32'h55667788);
        m1_req_valid = 1; m1_req_addr = 32'h0000_000C; m1_req_we = 1; m1_req_be = 4'b1111; m1_req_wdata = 32'h99999999;
        @(negedge clk);
        m1_req_valid = 0;
        checks++;
        if (dram_we !== 1'b1) begin errors++; $display("FAIL rst_access_we got %b want 1", dram_we); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({dram_we, dram_be} !== 5'b0) begin
            errors++; $display("FAIL rst_we_drop we=%b be=%b want 0", dram_we, dram_be);
        end
        @(negedge clk);
        checks++;
        if (mem[3] !== 32'h55667788) begin errors++; $display("FAIL rst_mem got %h want 55667788", mem[3]); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({m0_req_ready, m1_req_ready, m0_rsp_valid, m1_rsp_valid, m0_rsp_rdata, dram_a, dram_we, dram_be, dram_d} !== '0) begin
            errors++; $display("FAIL rst_release_outputs rsp_v=%b%b rdata=%h a=%h we=%b be=%b d=%h want all 0",
                               m0_rsp_valid, m1_rsp_valid, m0_rsp_rdata, dram_a, dram_we, dram_be, dram_d);
        end
        m0_req_valid = 1; m0_req_addr = 32'h0000_000C; m0_req_we = 0;
        #1;
        checks++;
        if (m0_req_ready !== 1'b1) begin errors++; $display("FAIL rst_idle_ready got %b want 1", m0_req_ready); end
        @(negedge clk);
        m0_req_valid = 0;
        @(negedge clk);
        checks++;
        if ({m0_rsp_valid, m0_rsp_rdata} !== {1'b1, 32'h55667788}) begin
            errors++; $display("FAIL rst_readback v=%b rdata=%h want 1 55667788", m0_rsp_valid, m0_rsp_rdata);
        end
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        poke = 0; poke_a = 0; poke_d = 0;
        idle_inputs;
        test_reset;
        test_read;
        test_write;
        test_arbitration;
        test_backpressure;
        test_reset_mid_access;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dram_arbiter.md
# dram_arbiter

Two-master arbiter and sequencer for the single-port word-addressed data DRAM of the TinyCPU test platform. It accepts byte-addressed requests from the instruction-fetch master (m0) and the load/store master (m1) over valid/ready handshakes. It serialises them onto the DRAM's shared `a/be/we/d/spo` port and returns each result over a buffered, back-pressurable response channel. It sits between the core's memory stages and the DRAM model.

## Interface
- `ADDR_BITS`, 20: DRAM word-address width; must match the DRAM instance.
- `clk` input 1: single clock; everything is sampled on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `mX_req_valid` input 1 (X = 0,1): request present.
- `mX_req_ready` output 1: request accepted when `valid & ready`.
- `mX_req_addr` input 32: byte address; bits [1:0] are ignored.
- `mX_req_we` input 1: 1 = write, 0 = read.
- `mX_req_be` input 4: byte enables; only meaningful for writes.
- `mX_req_wdata` input 32: write data.
- `mX_rsp_valid` output 1: response present.
- `mX_rsp_ready` input 1: master consumes the response.
- `mX_rsp_rdata` output 32: word read at that address. For a write, this is the pre-write contents.
- `dram_a` output ADDR_BITS: equals latched `addr[ADDR_BITS+1:2]`.
- `dram_be` output 4, `dram_we` output 1, `dram_d` output 32: DRAM write controls.
- `dram_spo` input 32: asynchronous read data from the DRAM.

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset state is IDLE.
- IDLE:
  - The grant logic selects at most one master with `req_valid`.
  - `req_ready` is 1 only for the selected master, and is combinational from valid and state.
  - On the handshake, the arbiter latches addr/we/be/wdata and the grant id, then moves to ACCESS.
  - With no valid request, it stays in IDLE.
- ACCESS (exactly one cycle):
  - `dram_a` is driven from the latch; `dram_we` = latched we; `dram_be` = latched be (0 for reads); `dram_d` = latched wdata.
  - `dram_spo` is captured into the rdata register at the end of the cycle.
  - Moves to RESP.
- RESP:
  - The granted master sees `rsp_valid` = 1 with stable `rsp_rdata`.
  - On `rsp_ready`, the FSM returns to IDLE. The next request is not accepted in that same cycle.
  - Back-pressure holds RESP indefinitely. The other master's `req_ready` stays 0 throughout.
- Outside ACCESS: `dram_we` = 0 and `dram_be` = 0; `dram_a`/`dram_d` hold the last latched value.
- Default arbitration is fixed priority: m1 beats m0 on simultaneous valid.
- The non-granted `rsp_valid` is always 0; only one transaction is ever outstanding.
- Reset mid-operation:
  - FSM → IDLE immediately (asynchronously).
  - Any pending transaction is dropped; no DRAM write issues after `rst_n` falls.
  - No response is produced for the dropped transaction.

## Timing
- All registered outputs reset to 0: `rsp_valid`, `rsp_rdata`, the latch, `dram_*`. `req_ready` is also 0 during reset.
- Cycle sequence: handshake in cycle N → DRAM access in N+1 → `rsp_valid` rises in N+2.
- Minimum spacing between accepted requests is 3 cycles (zero-wait response).
- A write commits to DRAM at the clock edge ending cycle N+1.
- A read issued after a write sees the new data.

## Configuration
- `DRAM_ARB_RR_EN` defined: round-robin arbitration.
  - A `last_grant` register (reset value 1, so m0 wins the first contention) flips on every accepted request.
  - On simultaneous valid, the master other than `last_grant` wins.
  - A lone requester always wins.
- `DRAM_ARB_RR_EN` undefined: fixed priority, m1 over m0. The `last_grant` register is not present.

## Structure
- `dram_arb_pkg` holds:
  - the state enum (IDLE/ACCESS/RESP);
  - the master-id constants (M_IF = 0, M_LS = 1);
  - the request struct (addr, we, be, wdata).
- Sub-module `dram_arb_grant`:
  - inputs: two valids, `last_grant`; output: grant id + grant-valid;
  - contains the `DRAM_ARB_RR_EN` selection.
- The top level holds the FSM, the request latch, the rdata register and the DRAM drive.

## Test plan
- m0 reads 0x0000_0010, DRAM word 4 = 0xDEADBEEF → `dram_a` = 4 in N+1; `m0_rsp_valid` in N+2 with rdata 0xDEADBEEF.
- m1 writes 0x0000_0008 with be=4'b0101, wdata 0x11223344 over 0xAABBCCDD → rsp rdata 0xAABBCCDD; a subsequent read returns 0xAA22CC44.
- Both masters valid together, repeated 4 times:
  - fixed build: m1, m1, m1, m1 (m0 starves while m1 is valid);
  - `DRAM_ARB_RR_EN` build: m0, m1, m0, m1.
- m0 holds `rsp_ready` = 0 for 5 cycles while m1 is valid → `m1_req_ready` stays 0 and rdata stays stable. m1 is accepted the cycle after `m0_rsp_ready`, i.e. in IDLE.
- `rst_n` pulled low during ACCESS of an m1 write → `dram_we` drops immediately and memory is unchanged. After release, all outputs are 0 and the FSM is in IDLE.
